// File: rtl/conbus_wb_slave_mem_pkg.sv
// Shared types, bus-width defaults and address-window helper for conbus_wb_slave_mem.
package conbus_wb_slave_mem_pkg;

    localparam int unsigned dw = 32;
    localparam int unsigned aw = 32;
    localparam int unsigned sw = dw / 8;

    typedef enum logic [1:0] {RESP_ACK, RESP_ERR, RESP_RTY} resp_e;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    // Window test is done one bit wider so BASE + span never wraps at the top of the map.
    function automatic logic in_window(input logic [aw-1:0] adr,
                                       input logic [aw-1:0] base,
                                       input int unsigned   depth_log2);
        logic [aw:0] off;
        logic [aw:0] span;
        off  = {1'b0, adr} - {1'b0, base};
        span = (aw+1)'(4) << depth_log2;
        return (adr >= base) && (off < span);
    endfunction

endpackage

// File: rtl/conbus_wb_slave_mem_if.sv
// Wishbone classic slave-port bundle as seen from the conbus crossbar.
interface conbus_wb_slave_mem_if #(
    parameter int unsigned dw = conbus_wb_slave_mem_pkg::dw,
    parameter int unsigned aw = conbus_wb_slave_mem_pkg::aw,
    parameter int unsigned sw = conbus_wb_slave_mem_pkg::sw
);
    logic          cyc_i;
    logic          stb_i;
    logic          we_i;
    logic          cab_i;
    logic [aw-1:0] adr_i;
    logic [sw-1:0] sel_i;
    logic [dw-1:0] dat_i;
    logic          hold_i;
    logic [dw-1:0] dat_o;
    logic          ack_o;
    logic          err_o;
    logic          rty_o;

    modport slave  (input  cyc_i, stb_i, we_i, cab_i, adr_i, sel_i, dat_i, hold_i,
                    output dat_o, ack_o, err_o, rty_o);
    modport master (output cyc_i, stb_i, we_i, cab_i, adr_i, sel_i, dat_i, hold_i,
                    input  dat_o, ack_o, err_o, rty_o);
endinterface

// File: rtl/conbus_wb_slave_mem_bytelane_ram.sv
// Word RAM with per-byte-lane write enables and asynchronous read; contents are not reset.
module conbus_bytelane_ram #(
    parameter int unsigned dw         = conbus_wb_slave_mem_pkg::dw,
    parameter int unsigned sw         = conbus_wb_slave_mem_pkg::sw,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk_i,
    input  logic [sw-1:0]         we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [dw-1:0]         wdata_i,
    output logic [dw-1:0]         rdata_o
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [dw-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int unsigned l = 0; l < sw; l++) begin
            if (we_i[l]) mem_q[addr_i][8*l +: 8] <= wdata_i[8*l +: 8];
        end
    end

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/conbus_wb_slave_mem.sv
// Wishbone classic memory slave with programmable wait states and ack/err/rty responses.
// Define CONBUS_SLAVE_BURST_EN for back-to-back acks on cab_i bursts.
module conbus_wb_slave_mem
    import conbus_wb_slave_mem_pkg::*;
#(
    parameter int unsigned   dw          = conbus_wb_slave_mem_pkg::dw,
    parameter int unsigned   aw          = conbus_wb_slave_mem_pkg::aw,
    parameter int unsigned   sw          = conbus_wb_slave_mem_pkg::sw,
    parameter int unsigned   DEPTH_LOG2  = 8,
    parameter logic [aw-1:0] BASE_ADDR   = '0,
    parameter int unsigned   WAIT_STATES = 1
) (
    input logic                  clk_i,
    input logic                  rst_i,
    conbus_wb_slave_mem_if.slave bus
);
    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [aw-1:0] adr_q;
    logic          we_q;
    logic          hold_q;
    logic [sw-1:0] sel_q;
    logic [dw-1:0] wdat_q;
    logic [dw-1:0] rdat_q;
    logic          ack_q, err_q, rty_q;

    logic          start, wait_done, burst_go, live, enter_resp;
    logic [aw-1:0] b_adr, b_off;
    logic          b_we, b_hold;
    logic [sw-1:0] b_sel, ram_we;
    logic [dw-1:0] b_dat, ram_rdata;
    resp_e         b_resp;
    logic          unused_bits;

    assign start     = (state_q == IDLE) && bus.cyc_i && bus.stb_i;
    assign wait_done = (state_q == WAIT) && bus.cyc_i && (cnt_q == 4'd1);

`ifdef CONBUS_SLAVE_BURST_EN
    assign burst_go = (state_q == RESP) && ack_q && bus.cab_i && bus.cyc_i
                      && bus.stb_i && !bus.hold_i;
`else
    assign burst_go = 1'b0;
`endif

    // Beats answered without a wait cycle decode straight off the bus; others use the latched beat.
    assign live       = burst_go || (start && (WAIT_STATES == 0));
    assign enter_resp = live || wait_done;

    assign b_adr  = live ? bus.adr_i  : adr_q;
    assign b_we   = live ? bus.we_i   : we_q;
    assign b_sel  = live ? bus.sel_i  : sel_q;
    assign b_dat  = live ? bus.dat_i  : wdat_q;
    assign b_hold = live ? bus.hold_i : hold_q;
    assign b_off  = b_adr - BASE_ADDR;

    always_comb begin
        b_resp = RESP_ACK;
        if (b_hold) begin
            b_resp = RESP_RTY;
        end else if (!in_window(b_adr, BASE_ADDR, DEPTH_LOG2) || (b_adr[1:0] != 2'b00)
                     || (b_sel == '0)) begin
            b_resp = RESP_ERR;
        end
    end

    assign ram_we      = (enter_resp && (b_resp == RESP_ACK) && b_we) ? b_sel : '0;
    assign unused_bits = ^{b_off, bus.cab_i};

    conbus_bytelane_ram #(
        .dw         (dw),
        .sw         (sw),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .addr_i  (b_off[DEPTH_LOG2+1:2]),
        .wdata_i (b_dat),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            hold_q  <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            rty_q <= 1'b0;
            if (start) begin
                adr_q  <= bus.adr_i;
                we_q   <= bus.we_i;
                sel_q  <= bus.sel_i;
                wdat_q <= bus.dat_i;
                hold_q <= bus.hold_i;
            end
            if (enter_resp) begin
                state_q <= RESP;
                cnt_q   <= '0;
                ack_q   <= (b_resp == RESP_ACK);
                err_q   <= (b_resp == RESP_ERR);
                rty_q   <= (b_resp == RESP_RTY);
                if ((b_resp == RESP_ACK) && !b_we) rdat_q <= ram_rdata;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            cnt_q   <= 4'(WAIT_STATES);
                            state_q <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (!bus.cyc_i) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                    RESP:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.dat_o = rdat_q;
    assign bus.ack_o = ack_q;
    assign bus.err_o = err_q;
    assign bus.rty_o = rty_q;
endmodule

// File: tb/tb_conbus_wb_slave_mem.sv
// Directed scoreboard bench: three slaves (WAIT_STATES 1/2/3, the last at base 0x1000).
module tb_conbus_wb_slave_mem;
    import conbus_wb_slave_mem_pkg::*;

    typedef struct {
        resp_e       kind;
        int          cyc;
        logic [31:0] dato;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, cab = 1'b0, hold = 1'b0;
    logic [31:0] adr = '0, dat = '0;
    logic [3:0]  sel = '0;
    int          dsel = 0;
    int          cyc_n = 0;
    int          n_vec = 0, n_miss = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] last_rd [3];
    logic        r_ack, r_err, r_rty;
    logic [31:0] r_dat;
    logic [31:0] badr [4];
    resp_e       bkind [4];
    logic [31:0] bdat [4];
    bit          got;

    conbus_wb_slave_mem_if b1 ();
    conbus_wb_slave_mem_if b2 ();
    conbus_wb_slave_mem_if b3 ();

    assign b1.cyc_i = cyc && (dsel == 0);
    assign b2.cyc_i = cyc && (dsel == 1);
    assign b3.cyc_i = cyc && (dsel == 2);
    assign b1.stb_i = stb;  assign b2.stb_i = stb;  assign b3.stb_i = stb;
    assign b1.we_i  = we;   assign b2.we_i  = we;   assign b3.we_i  = we;
    assign b1.cab_i = cab;  assign b2.cab_i = cab;  assign b3.cab_i = cab;
    assign b1.adr_i = adr;  assign b2.adr_i = adr;  assign b3.adr_i = adr;
    assign b1.sel_i = sel;  assign b2.sel_i = sel;  assign b3.sel_i = sel;
    assign b1.dat_i = dat;  assign b2.dat_i = dat;  assign b3.dat_i = dat;
    assign b1.hold_i = hold; assign b2.hold_i = hold; assign b3.hold_i = hold;

    conbus_wb_slave_mem #(.WAIT_STATES(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(b1));
    conbus_wb_slave_mem #(.WAIT_STATES(2)) dut2 (.clk_i(clk), .rst_i(rst), .bus(b2));
    conbus_wb_slave_mem #(.WAIT_STATES(3), .BASE_ADDR(32'h0000_1000))
        dut3 (.clk_i(clk), .rst_i(rst), .bus(b3));

    always_comb begin
        case (dsel)
            0:       begin r_ack = b1.ack_o; r_err = b1.err_o; r_rty = b1.rty_o; r_dat = b1.dat_o; end
            1:       begin r_ack = b2.ack_o; r_err = b2.err_o; r_rty = b2.rty_o; r_dat = b2.dat_o; end
            default: begin r_ack = b3.ack_o; r_err = b3.err_o; r_rty = b3.rty_o; r_dat = b3.dat_o; end
        endcase
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Instance k runs with WAIT_STATES = k + 1.
    function automatic int ws_of(input int k);
        return k + 1;
    endfunction

    function automatic logic [63:0] onehot(input resp_e k);
        case (k)
            RESP_ACK: return 64'd1;
            RESP_ERR: return 64'd2;
            default:  return 64'd4;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (r_ack || r_err || r_rty) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", {61'd0, r_rty, r_err, r_ack}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.tag, "_kind"}, {61'd0, r_rty, r_err, r_ack}, onehot(mon_e.kind));
                chk({mon_e.tag, "_cycle"}, 64'(cyc_n), 64'(mon_e.cyc));
                chk({mon_e.tag, "_dat"}, {32'd0, r_dat}, {32'd0, mon_e.dato});
            end
        end
    end

    task automatic beat(input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit h, input resp_e k,
                        input logic [31:0] rd, input string tag);
        exp_t e;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d; hold = h; cab = 1'b0;
        if (k == RESP_ACK && !w) last_rd[dsel] = rd;
        e.kind = k; e.cyc = cyc_n + 1 + ws_of(dsel); e.dato = last_rd[dsel]; e.tag = tag;
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = r_ack || r_err || r_rty;
        end
        chk({tag, "_seen"}, 64'(got), 64'd1);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; hold = 1'b0;
    endtask

    // Master advances the address on each response; with cab the slave takes it the same cycle.
    task automatic run_burst(input int n, input string tag);
        exp_t e;
        int   step;
        int   idx;
`ifdef CONBUS_SLAVE_BURST_EN
        step = 1;
`else
        step = ws_of(1) + 2;
`endif
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            if (bkind[i] == RESP_ACK) last_rd[1] = bdat[i];
            e.kind = bkind[i]; e.cyc = cyc_n + 1 + ws_of(1) + i * step;
            e.dato = last_rd[1]; e.tag = $sformatf("%s_b%0d", tag, i);
            sb.push_back(e);
        end
        cyc = 1'b1; stb = 1'b1; cab = 1'b1; we = 1'b0; sel = 4'hF; hold = 1'b0; adr = badr[0];
        idx = 0;
        for (int t = 0; t < 60 && idx < n; t++) begin
            @(negedge clk);
            if (r_ack || r_err || r_rty) begin
                idx++;
                if (idx < n) adr = badr[idx];
                else begin cyc = 1'b0; stb = 1'b0; cab = 1'b0; end
            end
        end
        chk({tag, "_beats"}, 64'(idx), 64'(n));
        cyc = 1'b0; stb = 1'b0; cab = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 3; k++) last_rd[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            dsel = k; #1;
            chk($sformatf("reset_resp%0d", k), {61'd0, r_rty, r_err, r_ack}, 64'd0);
            chk($sformatf("reset_dat%0d", k), {32'd0, r_dat}, 64'd0);
        end
        rst = 1'b0;
        dsel = 0;

        beat(1, 32'h10, 4'hF, 32'hDEADBEEF, 0, RESP_ACK, '0, "wr10");
        beat(0, 32'h10, 4'hF, '0, 0, RESP_ACK, 32'hDEADBEEF, "rd10");
        beat(1, 32'h14, 4'hF, 32'h11223344, 0, RESP_ACK, '0, "wr14_full");
        beat(1, 32'h14, 4'b0101, 32'hAABBCCDD, 0, RESP_ACK, '0, "wr14_lanes");
        beat(0, 32'h14, 4'hF, '0, 0, RESP_ACK, 32'h11BB33DD, "rd14_lanes");
        beat(0, 32'h400, 4'hF, '0, 0, RESP_ERR, '0, "rd_oow");
        beat(1, 32'h12, 4'hF, 32'h0, 0, RESP_ERR, '0, "wr_misalign");
        beat(1, 32'h10, 4'h0, 32'h0, 0, RESP_ERR, '0, "wr_sel0");
        beat(0, 32'h10, 4'hF, '0, 0, RESP_ACK, 32'hDEADBEEF, "rd10_kept");
        beat(1, 32'h3FC, 4'hF, 32'h5A5A0FF0, 0, RESP_ACK, '0, "wr_top");
        beat(0, 32'h3FC, 4'hF, '0, 0, RESP_ACK, 32'h5A5A0FF0, "rd_top");
        beat(1, 32'h30, 4'hF, 32'h12345678, 0, RESP_ACK, '0, "wr30");
        beat(1, 32'h30, 4'hF, 32'hAAAA5555, 1, RESP_RTY, '0, "wr30_hold");
        beat(0, 32'h30, 4'hF, '0, 1, RESP_RTY, '0, "rd30_hold");
        beat(0, 32'h30, 4'hF, '0, 0, RESP_ACK, 32'h12345678, "rd30_kept");
        beat(1, 32'h30, 4'hF, 32'hAAAA5555, 0, RESP_ACK, '0, "wr30_retry");
        beat(0, 32'h30, 4'hF, '0, 0, RESP_ACK, 32'hAAAA5555, "rd30_new");

        // Reset while the write ack is on the bus: outputs drop at once, the write already landed.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h40; dat = 32'hCAFEF00D; sel = 4'hF;
        sb.push_back('{RESP_ACK, cyc_n + 1 + ws_of(0), last_rd[0], "rst_wr"});
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = r_ack;
        end
        chk("rst_wr_seen", 64'(got), 64'd1);
        #1 rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        #1;
        chk("rst_in_resp_ack", 64'(r_ack), 64'd0);
        chk("rst_in_resp_dat", {32'd0, r_dat}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) last_rd[k] = '0;
        beat(0, 32'h40, 4'hF, '0, 0, RESP_ACK, 32'hCAFEF00D, "rd40_after_rst");

        dsel = 2;
        beat(1, 32'h1020, 4'hF, 32'h01020304, 0, RESP_ACK, '0, "ws3_wr");
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h1020; dat = 32'hFFFFFFFF; sel = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("abort_quiet", 64'(sb.size()), 64'd0);
        beat(0, 32'h1020, 4'hF, '0, 0, RESP_ACK, 32'h01020304, "ws3_rd_after_abort");
        beat(0, 32'h0FFC, 4'hF, '0, 0, RESP_ERR, '0, "ws3_below_base");
        beat(0, 32'h1400, 4'hF, '0, 0, RESP_ERR, '0, "ws3_above_top");
        beat(1, 32'h13FC, 4'hF, 32'h77665544, 0, RESP_ACK, '0, "ws3_wr_top");
        beat(0, 32'h13FC, 4'hF, '0, 0, RESP_ACK, 32'h77665544, "ws3_rd_top");

        dsel = 1;
        for (int i = 0; i < 4; i++) begin
            bdat[i] = 32'hB0000000 + 32'(i * 17 + 1);
            beat(1, 32'(i * 4), 4'hF, bdat[i], 0, RESP_ACK, '0, $sformatf("ws2_wr%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            badr[i] = 32'(i * 4);
            bkind[i] = RESP_ACK;
        end
        run_burst(4, "burst4");
        badr[0] = 32'h4;   bkind[0] = RESP_ACK; bdat[0] = bdat[1];
        badr[1] = 32'h400; bkind[1] = RESP_ERR;
        run_burst(2, "burst_err");
        repeat (4) @(posedge clk);
        #1 chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
